spi_bus_master: RTL and testbench
=================================

# spi_bus_master

SPI target that lets the board microcontroller read and write the 17-bit system address space. It parses framed SPI commands, drives the address/data/strobe side of the bus that the address decoder consumes, and waits for a grant from the bus arbiter before completing each cycle. It sits between the MCU SPI pins and the bus arbiter, beside the 6502 as a second bus initiator.

## Interface

No parameters.

- clk  in  1  system clock, 64 MHz
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- spi_sclk  in  1  SPI clock from MCU, asynchronous, ≤ clk/8
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  SPI data out, MSB first
- spi_stall  out  1  high while a bus cycle is pending; MCU must not complete another command byte
- bus_req  out  1  bus cycle request to arbiter
- bus_addr  out  17  cycle address
- bus_we  out  1  1 = write, 0 = read
- bus_wr_data  out  8  write data
- bus_rd_data  in  8  read data, valid in the cycle bus_grant is high
- bus_grant  in  1  one-clock pulse: cycle done

## Operation

- SPI mode 0. sclk, cs_n and mosi pass through 2-FF synchronizers. mosi is sampled on the synchronized sclk rising edge, and miso is updated on the falling edge. A 3-bit counter assembles each byte.
- cs_n high: bit counter = 0, parser = CMD, miso shift register holds its last loaded value. cs_n rising mid-byte discards the partial byte. A pending bus cycle is not cancelled.
- Command byte, first byte of each frame (A = bit 0 = addr[16]):
  - 1000_000A WRITE: followed by ADDR_HI (addr[15:8]), ADDR_LO (addr[7:0]) and DATA. The cycle is issued after DATA.
  - 1100_000A READ: followed by ADDR_HI and ADDR_LO. The cycle is issued after ADDR_LO. The next byte clocked shifts out the read data.
  - 0100_0000 WRITE_NEXT: followed by DATA. Uses the current address register.
  - 0110_0000 READ_NEXT: the cycle is issued immediately. The next byte shifts out the read data.
  - Any other value: parser → DISCARD, which ignores all bytes until cs_n goes high.
- After a command's final byte, the parser returns to CMD, so commands may be chained within one frame.
- Parser states are CMD, ADDR_HI, ADDR_LO, DATA and DISCARD.
- Bus FSM:
  - IDLE → REQ on the final byte of a command: bus_req = 1, addr/we/wr_data latched.
  - REQ → IDLE on bus_grant.
  - On a read grant, bus_rd_data is loaded into the miso shift register.
  - On any grant, the address register increments modulo 2^17 (1_FFFF → 0_0000).
- A command that completes while in REQ is dropped: no cycle is issued, and address and data are unchanged.

## Timing

- Reset values: spi_miso 0, spi_stall 0, bus_req 0, bus_addr 0, bus_we 0, bus_wr_data 0. Address register 0, parser CMD, bus FSM IDLE.
- Synchronizer latency: 2 clk. A sclk edge is acted on 3 clk after the pin edge.
- bus_req rises in the clk cycle after the final bit of the triggering byte is shifted in.
- bus_addr, bus_we and bus_wr_data are stable for the whole time bus_req is high.
- bus_grant is sampled only while bus_req = 1. In the grant cycle:
  - read data is captured;
  - bus_req falls on the next edge;
  - bus_addr shows the incremented value from that next edge.
- spi_stall equals bus_req, registered with it, with no extra latency.
- Grant in the same cycle as a new command's completion: the grant is processed and the new command is dropped.
- reset mid-cycle: bus_req drops on the next edge. The arbiter must ignore a grant after reset.

## Test plan

- Reset, then idle: all outputs 0. An ignored bus_grant pulse changes nothing.
- WRITE 0x81, 0xE8, 0x10, 0x5A:
  - bus_req high, bus_addr = 0x1E810, bus_we = 1, bus_wr_data = 0x5A.
  - Grant after 5 clk: bus_req low next cycle, bus_addr = 0x1E811, spi_stall low.
- READ 0xC0, 0x80, 0x00; arbiter returns 0xA5:
  - bus_addr = 0x08000, bus_we = 0.
  - The following SPI byte shifts out 0xA5 on miso.
  - READ_NEXT 0x60 issues 0x08001.
- Address wrap: WRITE 0x81, 0xFF, 0xFF, 0x11, then WRITE_NEXT 0x40, 0x22 → second cycle at bus_addr = 0x00000 with data 0x22.
- Framing errors:
  - cs_n rises after 4 bits of ADDR_HI → no cycle; the next frame parses from CMD.
  - Command 0x00 → DISCARD; a following 0x81, ... in the same frame issues no cycle.
- Overrun: WRITE_NEXT 0x40, 0x33 completed while the previous cycle is ungranted (grant withheld 100 clk) → exactly one cycle observed, with the original data, and bus_addr increments once.

Source files
------------

// File: rtl/spi_bus_master.sv
// SPI mode-0 target that turns framed MCU commands into single 17-bit-address bus cycles.
// A second bus initiator beside the CPU: it raises bus_req and waits for a one-clock grant from the arbiter.
module spi_bus_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_stall,
  output logic        bus_req,
  output logic [16:0] bus_addr,
  output logic        bus_we,
  output logic [7:0]  bus_wr_data,
  input  logic [7:0]  bus_rd_data,
  input  logic        bus_grant
);

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {P_CMD, P_ADDR_HI, P_ADDR_LO, P_DATA, P_DISCARD} parse_e;
  typedef enum logic {B_IDLE, B_REQ} bus_e;

  // sclk carries a third stage so its edges can be detected after synchronization
  logic [2:0]        sclk_pipe_q, sclk_pipe_d;
  logic [1:0]        cs_pipe_q, cs_pipe_d;
  logic [1:0]        mosi_pipe_q, mosi_pipe_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  parse_e            parse_q, parse_d;
  logic [ADDR_W-1:0] stg_addr_q, stg_addr_d;
  logic              stg_read_q, stg_read_d;
  logic              stg_next_q, stg_next_d;
  bus_e              bus_q, bus_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              sclk_rise_c, sclk_fall_c, cs_high_c, mosi_c;
  logic [DATA_W-1:0] rx_byte_c;
  logic              issue_c, issue_we_c;
  logic [ADDR_W-1:0] issue_addr_c;
  logic [DATA_W-1:0] issue_data_c;

  assign sclk_rise_c = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall_c = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign cs_high_c   = cs_pipe_q[1];
  assign mosi_c      = mosi_pipe_q[1];
  assign rx_byte_c   = {rx_q, mosi_c};

  always_comb begin
    sclk_pipe_d  = {sclk_pipe_q[1:0], spi_sclk};
    cs_pipe_d    = {cs_pipe_q[0], spi_cs_n};
    mosi_pipe_d  = {mosi_pipe_q[0], spi_mosi};
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    parse_d      = parse_q;
    stg_addr_d   = stg_addr_q;
    stg_read_d   = stg_read_q;
    stg_next_d   = stg_next_q;
    bus_d        = bus_q;
    req_d        = req_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    issue_c      = 1'b0;
    issue_we_c   = 1'b0;
    issue_addr_c = addr_q;
    issue_data_c = wdata_q;

    // Byte assembly and command parser
    if (cs_high_c) begin
      bit_cnt_d = '0;
      parse_d   = P_CMD;
    end else if (sclk_rise_c) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      rx_d      = rx_byte_c[DATA_W-2:0];
      if (bit_cnt_q == CNT_W'(7)) begin
        case (parse_q)
          P_CMD: begin
            if (rx_byte_c[7:1] == 7'b1000_000) begin
              stg_read_d     = 1'b0;
              stg_next_d     = 1'b0;
              stg_addr_d[16] = rx_byte_c[0];
              parse_d        = P_ADDR_HI;
            end else if (rx_byte_c[7:1] == 7'b1100_000) begin
              stg_read_d     = 1'b1;
              stg_next_d     = 1'b0;
              stg_addr_d[16] = rx_byte_c[0];
              parse_d        = P_ADDR_HI;
            end else if (rx_byte_c == 8'h40) begin
              stg_read_d = 1'b0;
              stg_next_d = 1'b1;
              parse_d    = P_DATA;
            end else if (rx_byte_c == 8'h60) begin
              issue_c      = 1'b1;
              issue_we_c   = 1'b0;
              issue_addr_c = addr_q;
              parse_d      = P_CMD;
            end else begin
              parse_d = P_DISCARD;
            end
          end
          P_ADDR_HI: begin
            stg_addr_d[15:8] = rx_byte_c;
            parse_d          = P_ADDR_LO;
          end
          P_ADDR_LO: begin
            stg_addr_d[7:0] = rx_byte_c;
            if (stg_read_q) begin
              issue_c      = 1'b1;
              issue_we_c   = 1'b0;
              issue_addr_c = {stg_addr_q[16:8], rx_byte_c};
              parse_d      = P_CMD;
            end else begin
              parse_d = P_DATA;
            end
          end
          P_DATA: begin
            issue_c      = 1'b1;
            issue_we_c   = 1'b1;
            issue_addr_c = stg_next_q ? addr_q : stg_addr_q;
            issue_data_c = rx_byte_c;
            parse_d      = P_CMD;
          end
          default: parse_d = P_DISCARD;
        endcase
      end
    end else if (sclk_fall_c && (bit_cnt_q != '0)) begin
      // no shift on the fall that closes a byte, so a freshly loaded MSB survives
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end

    // Bus cycle FSM; commands finishing while a cycle is pending are dropped
    case (bus_q)
      B_IDLE: begin
        if (issue_c) begin
          bus_d   = B_REQ;
          req_d   = 1'b1;
          addr_d  = issue_addr_c;
          we_d    = issue_we_c;
          wdata_d = issue_we_c ? issue_data_c : wdata_q;
        end
      end
      B_REQ: begin
        if (bus_grant) begin
          bus_d  = B_IDLE;
          req_d  = 1'b0;
          addr_d = addr_q + ADDR_W'(1);
          if (!we_q) tx_d = bus_rd_data;
        end
      end
      default: bus_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_pipe_q <= '0;
      cs_pipe_q   <= '1;
      mosi_pipe_q <= '0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      parse_q     <= P_CMD;
      stg_addr_q  <= '0;
      stg_read_q  <= 1'b0;
      stg_next_q  <= 1'b0;
      bus_q       <= B_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      cs_pipe_q   <= cs_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      parse_q     <= parse_d;
      stg_addr_q  <= stg_addr_d;
      stg_read_q  <= stg_read_d;
      stg_next_q  <= stg_next_d;
      bus_q       <= bus_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
    end
  end

  assign spi_miso    = tx_q[DATA_W-1];
  assign spi_stall   = req_q;
  assign bus_req     = req_q;
  assign bus_addr    = addr_q;
  assign bus_we      = we_q;
  assign bus_wr_data = wdata_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Directed bench for spi_bus_master: MCU-side SPI driver, hand-played arbiter, immediate assertions.
module tb_spi_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_stall, bus_req, bus_we;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wr_data, bus_rd_data;
  logic        bus_grant;

  int checks = 0;
  int fails  = 0;
  int cycles = 0;
  logic req_prev = 1'b0;
  logic [7:0] mb;

  spi_bus_master dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_stall(spi_stall), .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_grant(bus_grant)
  );

  always #5 clk = ~clk;

  // counts bus cycles issued (rising edges of bus_req)
  always @(negedge clk) begin
    if (bus_req && !req_prev) cycles++;
    req_prev <= bus_req;
  end

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n bits MSB first, sclk half period 8 clk; miso sampled just before each rising edge
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      wait_clk(8);
      m[7-i] = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(8);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    spi_bits(b, 8, m);
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic frame_end();
    wait_clk(6);
    spi_cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic grant(input logic [7:0] rd);
    bus_rd_data = rd;
    bus_grant   = 1'b1;
    wait_clk(1);
    bus_grant   = 1'b0;
    bus_rd_data = 8'h00;
    wait_clk(1);
  endtask

  initial begin
    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    bus_rd_data = 8'h00; bus_grant = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);

    // reset / idle state
    check("rst_miso",  17'(spi_miso), 17'h0);
    check("rst_stall", 17'(spi_stall), 17'h0);
    check("rst_req",   17'(bus_req), 17'h0);
    check("rst_addr",  bus_addr, 17'h0);
    check("rst_we",    17'(bus_we), 17'h0);
    check("rst_wdata", 17'(bus_wr_data), 17'h0);
    grant(8'hFF);
    check("idle_grant_req",  17'(bus_req), 17'h0);
    check("idle_grant_addr", bus_addr, 17'h0);
    check("idle_grant_miso", 17'(spi_miso), 17'h0);

    // WRITE 0x1E810 <= 0x5A
    frame_start();
    spi_byte(8'h81, mb); spi_byte(8'hE8, mb); spi_byte(8'h10, mb); spi_byte(8'h5A, mb);
    check("wr_req",   17'(bus_req), 17'h1);
    check("wr_stall", 17'(spi_stall), 17'h1);
    check("wr_addr",  bus_addr, 17'h1E810);
    check("wr_we",    17'(bus_we), 17'h1);
    check("wr_data",  17'(bus_wr_data), 17'h5A);
    wait_clk(5);
    grant(8'h00);
    check("wr_done_req",   17'(bus_req), 17'h0);
    check("wr_done_stall", 17'(spi_stall), 17'h0);
    check("wr_done_addr",  bus_addr, 17'h1E811);
    frame_end();

    // READ 0x08000 returning 0xA5, then READ_NEXT clocks the data out
    frame_start();
    spi_byte(8'hC0, mb); spi_byte(8'h80, mb); spi_byte(8'h00, mb);
    check("rd_req",  17'(bus_req), 17'h1);
    check("rd_addr", bus_addr, 17'h08000);
    check("rd_we",   17'(bus_we), 17'h0);
    wait_clk(3);
    grant(8'hA5);
    check("rd_done_req",  17'(bus_req), 17'h0);
    check("rd_done_addr", bus_addr, 17'h08001);
    spi_byte(8'h60, mb);
    check("rd_miso",     17'(mb), 17'hA5);
    check("rdn_req",     17'(bus_req), 17'h1);
    check("rdn_addr",    bus_addr, 17'h08001);
    check("rdn_we",      17'(bus_we), 17'h0);
    grant(8'h3C);
    check("rdn_done_addr", bus_addr, 17'h08002);
    frame_end();
    frame_start();
    spi_byte(8'h00, mb);
    check("rdn_miso", 17'(mb), 17'h3C);
    frame_end();
    check("rdn_no_cycle", 17'(bus_req), 17'h0);

    // address wrap
    frame_start();
    spi_byte(8'h81, mb); spi_byte(8'hFF, mb); spi_byte(8'hFF, mb); spi_byte(8'h11, mb);
    check("wrap_addr", bus_addr, 17'h1FFFF);
    check("wrap_data", 17'(bus_wr_data), 17'h11);
    grant(8'h00);
    check("wrap_inc", bus_addr, 17'h00000);
    spi_byte(8'h40, mb); spi_byte(8'h22, mb);
    check("wrn_req",  17'(bus_req), 17'h1);
    check("wrn_addr", bus_addr, 17'h00000);
    check("wrn_data", 17'(bus_wr_data), 17'h22);
    check("wrn_we",   17'(bus_we), 17'h1);
    grant(8'h00);
    check("wrn_inc", bus_addr, 17'h00001);
    frame_end();

    // cs_n rises mid ADDR_HI, next frame parses from CMD
    frame_start();
    spi_byte(8'h81, mb); spi_bits(8'hF0, 4, mb);
    frame_end();
    wait_clk(10);
    check("frm_no_req", 17'(bus_req), 17'h0);
    frame_start();
    spi_byte(8'h81, mb); spi_byte(8'h00, mb); spi_byte(8'h20, mb); spi_byte(8'h77, mb);
    check("frm_addr", bus_addr, 17'h10020);
    check("frm_data", 17'(bus_wr_data), 17'h77);
    grant(8'h00);
    check("frm_inc", bus_addr, 17'h10021);
    frame_end();

    // bad command discards the rest of the frame
    frame_start();
    spi_byte(8'h00, mb);
    spi_byte(8'h81, mb); spi_byte(8'h12, mb); spi_byte(8'h34, mb); spi_byte(8'h56, mb);
    wait_clk(10);
    check("disc_req",  17'(bus_req), 17'h0);
    check("disc_addr", bus_addr, 17'h10021);
    frame_end();
    check("cycles_a", 17'(cycles), 17'd6);

    // overrun: second WRITE_NEXT completes while the first is ungranted
    frame_start();
    spi_byte(8'h40, mb); spi_byte(8'h33, mb);
    check("ovr_req",  17'(bus_req), 17'h1);
    check("ovr_addr", bus_addr, 17'h10021);
    check("ovr_data", 17'(bus_wr_data), 17'h33);
    spi_byte(8'h40, mb); spi_byte(8'h44, mb);
    wait_clk(100);
    check("ovr_keep_data", 17'(bus_wr_data), 17'h33);
    check("ovr_keep_addr", bus_addr, 17'h10021);
    grant(8'h00);
    check("ovr_done_req",  17'(bus_req), 17'h0);
    check("ovr_done_addr", bus_addr, 17'h10022);
    wait_clk(20);
    check("ovr_no_retry", 17'(bus_req), 17'h0);
    frame_end();
    check("cycles_b", 17'(cycles), 17'd7);

    // reset while a cycle is pending
    frame_start();
    spi_byte(8'h40, mb); spi_byte(8'h55, mb);
    check("rst_mid_req", 17'(bus_req), 17'h1);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    check("rst_mid_req_low", 17'(bus_req), 17'h0);
    check("rst_mid_stall",   17'(spi_stall), 17'h0);
    check("rst_mid_addr",    bus_addr, 17'h0);
    frame_end();
    check("cycles_c", 17'(cycles), 17'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
